// File: rtl/sop_feeder.sv
// Sample/coefficient feeder for an external sum-of-products core, with a credit-limited result FIFO.
// Optional `SOP_FEEDER_FLUSH_EN adds a flush input that restarts the delay-line fill.
module sop_feeder #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WIDTH-1:0]   s_data,
   input  logic               c_we,
   input  logic [1:0]         c_addr,
   input  logic [WIDTH-1:0]   c_data,
   output logic [WIDTH-1:0]   d1,
   output logic [WIDTH-1:0]   d2,
   output logic [WIDTH-1:0]   d3,
   output logic [WIDTH-1:0]   d4,
   output logic [WIDTH-1:0]   c1,
   output logic [WIDTH-1:0]   c2,
   output logic [WIDTH-1:0]   c3,
   output logic [WIDTH-1:0]   c4,
   input  logic [2*WIDTH+1:0] res_in,
`ifdef SOP_FEEDER_FLUSH_EN
   input  logic               flush,
`endif
   output logic               r_valid,
   input  logic               r_ready,
   output logic [2*WIDTH+1:0] r_data
);

   localparam int unsigned RW = 2*WIDTH + 2;

   typedef enum logic {FILL, RUN} state_t;

   state_t           state;
   logic [2:0]       count;
   logic [WIDTH-1:0] dl   [4];
   logic [WIDTH-1:0] coef [4];
   logic [LAT-1:0]   vpipe;
   logic [RW-1:0]    mem  [4];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [2:0]       occ;
   logic [2:0]       inflight;
   logic [3:0]       credits;
   logic             accept;
   logic             launch;
   logic             push;
   logic             pop;
   logic             flush_i;

`ifdef SOP_FEEDER_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   assign d1 = dl[0];
   assign d2 = dl[1];
   assign d3 = dl[2];
   assign d4 = dl[3];
   assign c1 = coef[0];
   assign c2 = coef[1];
   assign c3 = coef[2];
   assign c4 = coef[3];

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LAT; i++)
         inflight = inflight + {2'b00, vpipe[i]};
      credits = {1'b0, inflight} + {1'b0, occ};
      // Pre-fill accepts never launch, so they need no credit.
      s_ready = !flush_i && ((state == FILL && count < 3'd3) || credits < 4'd4);
      accept  = s_valid && s_ready;
      launch  = accept && (state == RUN || count == 3'd3);
      // A flush discards the launch emerging on the same edge as well.
      push    = vpipe[LAT-1] && !flush_i;
      r_valid = (occ != 3'd0);
      pop     = r_valid && r_ready;
      r_data  = r_valid ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FILL;
         count  <= '0;
         vpipe  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            dl[i]   <= '0;
            coef[i] <= '0;
         end
      end else begin
         if (c_we)
            coef[c_addr] <= c_data;
         if (flush_i) begin
            state <= FILL;
            count <= '0;
            vpipe <= '0;
            for (int unsigned i = 0; i < 4; i++)
               dl[i] <= '0;
         end else begin
            if (accept) begin
               dl[3] <= dl[2];
               dl[2] <= dl[1];
               dl[1] <= dl[0];
               dl[0] <= s_data;
               if (count != 3'd4)
                  count <= count + 3'd1;
               if (count == 3'd3)
                  state <= RUN;
            end
            vpipe[0] <= launch;
            for (int unsigned i = 1; i < LAT; i++)
               vpipe[i] <= vpipe[i-1];
         end
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         occ <= occ + {2'b00, push} - {2'b00, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= res_in;
   end

endmodule

// File: tb/tb_sop_feeder.sv
// Scoreboard bench for sop_feeder: a sample-history reference model predicts each result and s_ready.
// Define SOP_FEEDER_FLUSH_EN on both RTL and bench to exercise flush.
module tb_sop_feeder;

   localparam int W   = 4;
   localparam int LAT = 2;
   localparam int RW  = 2*W + 2;

   logic          clk = 0;
   logic          rst = 1;
   logic          s_valid = 0;
   logic          s_ready;
   logic [W-1:0]  s_data = '0;
   logic          c_we = 0;
   logic [1:0]    c_addr = '0;
   logic [W-1:0]  c_data = '0;
   logic [W-1:0]  d1, d2, d3, d4, c1, c2, c3, c4;
   logic [RW-1:0] res_in;
   logic          flush = 0;
   logic          r_valid;
   logic          r_ready = 1;
   logic [RW-1:0] r_data;

   sop_feeder #(.WIDTH(W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4),
      .c1(c1), .c2(c2), .c3(c3), .c4(c4),
      .res_in(res_in),
`ifdef SOP_FEEDER_FLUSH_EN
      .flush(flush),
`endif
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
   );

   always #5 clk = ~clk;

   // External SOP core: one register stage gives a 2-clock latency from d/c update.
   always @(posedge clk)
      res_in <= RW'(d1)*RW'(c1) + RW'(d2)*RW'(c2) + RW'(d3)*RW'(c3) + RW'(d4)*RW'(c4);

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;
   int results_seen = 0;

   always @(posedge clk) edge_n++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: history of accepted samples (index 0 newest) and coefficient table.
   typedef struct {
      logic [RW-1:0] v;
      int            t;
   } ent_t;

   ent_t         exp_q[$];
   logic [W-1:0] hist [4];
   logic [W-1:0] coef [4];
   int           fill = 0;

   function automatic logic [RW-1:0] model_sum();
      logic [RW-1:0] s = '0;
      for (int i = 0; i < 4; i++)
         s += RW'(hist[i]) * RW'(coef[i]);
      return s;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            hist[i] = '0;
            coef[i] = '0;
         end
         fill = 0;
         exp_q.delete();
      end else begin
         chk("s_ready", s_ready, !flush && (fill < 3 || exp_q.size() < 4));
         if (r_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", r_data, 32'hFFFF_FFFF);
            end else begin
               chk("r_data", r_data, exp_q[0].v);
               if (r_ready) begin
                  void'(exp_q.pop_front());
                  results_seen++;
               end
            end
         end else begin
            chk("r_data_empty", r_data, 0);
         end
         if (c_we)
            coef[c_addr] = c_data;
         if (flush) begin
            for (int i = 0; i < 4; i++)
               hist[i] = '0;
            fill = 0;
            while (exp_q.size() > 0 && exp_q[$].t + LAT >= edge_n + 1)
               void'(exp_q.pop_back());
         end else if (s_valid && s_ready) begin
            for (int i = 3; i > 0; i--)
               hist[i] = hist[i-1];
            hist[0] = s_data;
            if (fill < 4) fill++;
            if (fill == 4) begin
               ent_t e;
               e.v = model_sum();
               e.t = edge_n + 1;
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; s_valid = 0; c_we = 0; flush = 0; r_ready = 1;
      step(); step();
      rst = 0;
   endtask

   task automatic write_coefs(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d);
      logic [W-1:0] v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         c_we = 1; c_addr = 2'(i); c_data = v[i];
         step();
      end
      c_we = 0;
   endtask

   task automatic send(input logic [W-1:0] v);
      bit done = 0;
      s_valid = 1; s_data = v;
      for (int i = 0; i < 50 && !done; i++) begin
         if (s_ready) done = 1;
         step();
      end
      s_valid = 0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_result(input string name, input logic [RW-1:0] exp);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (r_valid && r_ready) begin
            got = 1;
            chk(name, r_data, exp);
         end
      end
      if (!got) chk({name, "_timeout"}, 0, 1);
      step();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_d"}, {d1, d2, d3, d4}, 0);
      chk({tag, "_c"}, {c1, c2, c3, c4}, 0);
      chk({tag, "_r_valid"}, r_valid, 0);
      chk({tag, "_r_data"}, r_data, 0);
      chk({tag, "_s_ready"}, s_ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int base;

      do_reset();
      chk_idle_outputs("reset");

      // Basic 20 / 30 results.
      write_coefs(1, 2, 3, 4);
      chk("coefs", {c1, c2, c3, c4}, {4'd1, 4'd2, 4'd3, 4'd4});
      send(1); send(2); send(3); send(4);
      wait_result("first_result", 20);
      send(5);
      wait_result("second_result", 30);

      // Three samples alone never produce a result.
      do_reset();
      write_coefs(1, 2, 3, 4);
      base = results_seen;
      send(2); send(3); send(4);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         seen += r_valid;
         step();
      end
      chk("no_early_result", seen, 0);
      send(5);
      for (int i = 0; i < 6; i++) step();
      chk("one_result_after_fill", results_seen - base, 1);

      // Backpressure: exactly four results queue, then drain in order.
      r_ready = 0;
      s_valid = 1;
      for (int i = 0; i < 10; i++) begin
         s_data = W'($urandom);
         step();
      end
      s_valid = 0;
      chk("bp_s_ready_low", s_ready, 0);
      chk("bp_r_valid", r_valid, 1);
      base = results_seen;
      r_ready = 1;
      for (int i = 0; i < 8; i++) step();
      chk("bp_drained_four", results_seen - base, 4);

      // Reset one cycle after a launch discards it.
      send(9);
      rst = 1;
      step();
      rst = 0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         seen += r_valid;
         step();
      end
      chk("post_reset_no_result", seen, 0);
      chk_idle_outputs("post_reset");

      // Coefficient write coincident with the 4th accept.
      write_coefs(1, 2, 3, 4);
      send(1); send(2); send(3);
      c_we = 1; c_addr = 2'd1; c_data = 4'd7;
      send(4);
      c_we = 0;
      wait_result("coef_same_edge", 35);

`ifdef SOP_FEEDER_FLUSH_EN
      // Flush keeps queued results and coefficients, restarts the fill.
      r_ready = 0;
      send(6); send(7);
      for (int i = 0; i < 4; i++) step();
      flush = 1;
      step();
      flush = 0;
      chk("flush_coefs", {c1, c2, c3, c4}, {4'd1, 4'd7, 4'd3, 4'd4});
      chk("flush_d_clear", {d1, d2, d3, d4}, 0);
      base = results_seen;
      r_ready = 1;
      for (int i = 0; i < 4; i++) step();
      chk("flush_queued_drain", results_seen - base, 2);
      base = results_seen;
      send(1); send(2); send(3);
      for (int i = 0; i < 6; i++) step();
      chk("flush_refill_none", results_seen - base, 0);
      send(4);
      for (int i = 0; i < 6; i++) step();
      chk("flush_refill_one", results_seen - base, 1);
`endif

      // Randomized traffic with occasional coefficient writes, stalls and resets.
      for (int i = 0; i < 600; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = W'($urandom);
         c_we    = ($urandom_range(0, 15) == 0);
         c_addr  = 2'($urandom);
         c_data  = W'($urandom);
         r_ready = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 199) == 0);
`ifdef SOP_FEEDER_FLUSH_EN
         flush   = ($urandom_range(0, 63) == 0);
`endif
         step();
      end
      rst = 0; s_valid = 0; c_we = 0; flush = 0; r_ready = 1;
      for (int i = 0; i < 12; i++) step();
      chk("final_scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sop_feeder.md
SOP_FEEDER -- requirements
Module: sop_feeder

Interface
REQ-001 Parameter WIDTH, default 4, sets the sample and coefficient width.
REQ-002 Parameter LAT, default 2, range 1..3, sets sum-of-products core latency in clocks, from d/c update to a valid res_in.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid / s_ready  input / output  1 / 1  sample handshake.
REQ-006 s_data  input  WIDTH  sample value.
REQ-007 c_we / c_addr / c_data  input  1 / 2 / WIDTH  coefficient write port.
REQ-008 d1..d4  output  WIDTH each  data taps to the SOP core; d1 is newest.
REQ-009 c1..c4  output  WIDTH each  coefficients to the SOP core.
REQ-010 res_in  input  2*WIDTH+2  final_out returned from the SOP core.
REQ-011 r_valid / r_ready  output / input  1 / 1  result handshake.
REQ-012 r_data  output  2*WIDTH+2  result at the FIFO head.

Function
REQ-013 A sample is accepted on any edge where s_valid and s_ready are both high; the delay line shifts: d4<=d3, d3<=d2, d2<=d1, d1<=s_data.
REQ-014 A write with c_we=1 sets c[c_addr+1]<=c_data on the same edge; a write coinciding with an accept takes effect before that accept's launch is evaluated.
REQ-015 FSM states: FILL (fill count <4) and RUN; FILL->RUN on the 4th accept; RUN is held until reset or flush.
REQ-016 A launch occurs on every accept that leaves the fill count at 4, i.e. the 4th accept in FILL and every accept in RUN.
REQ-017 Each launch enters a LAT-deep valid shift pipe; when it emerges, res_in is pushed into a 4-entry result FIFO on that edge.
REQ-018 credits = in-flight launches + FIFO occupancy; s_ready = 1 when (FILL and count<3) or credits<4, so the FIFO never overflows.
REQ-019 r_valid = FIFO non-empty; r_data = head entry, 0 when empty; the FIFO pops on r_valid and r_ready.
REQ-020 A push and a pop on the same edge leave occupancy unchanged; a push to an empty FIFO with r_ready high shows r_valid on the next cycle.
REQ-021 No arithmetic in this block; res_in is stored bit-exact with no truncation.
REQ-022 Maximum throughput is one sample and one result per clock when r_ready stays high.

Reset
REQ-023 On rst: d1..d4=0, c1..c4=0, count=0, state FILL, valid pipe cleared, FIFO empty, r_valid=0, r_data=0, s_ready=1.
REQ-024 Reset during operation discards in-flight launches and queued results; no result emerges after reset for any pre-reset launch.
REQ-025 rst overrides c_we, the accept and the flush on the same edge.

Configuration
REQ-026 Macro SOP_FEEDER_FLUSH_EN adds input port flush (1 bit).
REQ-027 With the macro defined, a high flush:
- clears d1..d4 and the count and forces FILL;
- clears the valid pipe;
- keeps the coefficients and FIFO contents;
- forces s_ready=0 that cycle.
REQ-028 Without the macro, the flush port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Under WIDTH=4, LAT=2: write c1..c4=1,2,3,4, then accept samples 1,2,3,4 -> one result r_data=20 (4*1+3*2+2*3+1*4); accept sample 5 -> next result 30.
REQ-030 Accept 3 samples after reset -> no r_valid for 10 cycles; the 4th sample yields exactly one result.
REQ-031 Hold r_ready=0 and stream in RUN -> s_ready drops once credits reach 4; exactly 4 results queue; raising r_ready drains them in order.
REQ-032 Assert rst one cycle after a launch -> r_valid stays 0, all outputs 0, s_ready=1.
REQ-033 With SOP_FEEDER_FLUSH_EN defined, pulse flush in RUN with 2 results queued -> the 2 results still drain; 4 new samples are needed before the next result; the coefficients are unchanged.
REQ-034 Write c2=7 on the same edge as the 4th accept -> the first result uses c2=7.
